// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared constants for the SIMD add/sub issue sequencer and adder
package simd_pkg;

    localparam int SIMD_W  = 256;
    localparam int RF_W    = 4;
    localparam int INSTR_W = 25;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_SUBI = 2'b11;

    localparam logic [2:0] MODE_8   = 3'd0;
    localparam logic [2:0] MODE_16  = 3'd1;
    localparam logic [2:0] MODE_32  = 3'd2;
    localparam logic [2:0] MODE_64  = 3'd3;
    localparam logic [2:0] MODE_128 = 3'd4;
    localparam logic [2:0] MODE_256 = 3'd5;
    localparam logic [2:0] MODE_MAX = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam int OP_MSB   = 24;
    localparam int OP_LSB   = 23;
    localparam int MODE_MSB = 22;
    localparam int MODE_LSB = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 16;
    localparam int RS1_MSB  = 15;
    localparam int RS1_LSB  = 12;
    localparam int RS2_MSB  = 11;
    localparam int RS2_LSB  = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    function automatic logic mode_illegal(input logic [2:0] mode);
        return mode > MODE_MAX;
    endfunction

    // Mask of the in-lane bit offset for a given lane-size mode.
    function automatic logic [7:0] lane_mask(input logic [2:0] mode);
        case (mode)
            MODE_8:   return 8'h07;
            MODE_16:  return 8'h0F;
            MODE_32:  return 8'h1F;
            MODE_64:  return 8'h3F;
            MODE_128: return 8'h7F;
            default:  return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/simd_adder.sv
// rtl/simd_adder.sv - combinational per-lane SIMD adder/subtractor
// Ports: a/b operands, data_mode lane size, sub_flag subtract, imm_flag use
// sign-extended imm_reg in place of b, out result. Carries never cross lanes.
module simd_adder
    import simd_pkg::*;
(
    input  logic [SIMD_W-1:0] a,
    input  logic [SIMD_W-1:0] b,
    input  logic [2:0]        data_mode,
    input  logic              sub_flag,
    input  logic              imm_flag,
    input  logic [7:0]        imm_reg,
    output logic [SIMD_W-1:0] out
);

    logic [7:0] lmask;
    logic [7:0] pos;
    logic       carry;
    logic       bb;

    // Ripple over all bits; the carry is reseeded at each lane's first bit
    // (with 1 for subtract, completing the two's complement of ~b).
    always_comb begin
        lmask = lane_mask(data_mode);
        out   = '0;
        carry = 1'b0;
        pos   = 8'd0;
        bb    = 1'b0;
        for (int i = 0; i < SIMD_W; i++) begin
            pos = 8'(i) & lmask;
            if (pos == 8'd0) begin
                carry = sub_flag;
            end
            if (imm_flag) begin
                bb = (pos > 8'd7) ? imm_reg[7] : imm_reg[pos[2:0]];
            end else begin
                bb = b[i];
            end
            bb     = bb ^ sub_flag;
            out[i] = a[i] ^ bb ^ carry;
            carry  = (a[i] & bb) | (carry & (a[i] ^ bb));
        end
    end

endmodule

// File: rtl/simd_add_issue.sv
// rtl/simd_add_issue.sv - sequencer issuing one SIMD add/sub instruction per 4 cycles
// Ports: instr_valid/instr_ready/instr front-end handshake; rf_raddr_a/b,
// rf_rdata_a/b register-file reads; rf_we/rf_waddr/rf_wdata write-back;
// add_* adder controls, add_out adder result; done/err_mode retire pulses.
// Optional SIMD_ISSUE_PERF_EN adds perf_retired/perf_illegal counters.
module simd_add_issue
    import simd_pkg::*;
#(
    parameter int SIMD_WIDTH = SIMD_W,
    parameter int RF_AW      = RF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    output logic [RF_AW-1:0]      rf_raddr_a,
    output logic [RF_AW-1:0]      rf_raddr_b,
    input  logic [SIMD_WIDTH-1:0] rf_rdata_a,
    input  logic [SIMD_WIDTH-1:0] rf_rdata_b,
    output logic                  rf_we,
    output logic [RF_AW-1:0]      rf_waddr,
    output logic [SIMD_WIDTH-1:0] rf_wdata,
    output logic [SIMD_WIDTH-1:0] add_a,
    output logic [SIMD_WIDTH-1:0] add_b,
    output logic [2:0]            add_data_mode,
    output logic                  add_sub_flag,
    output logic                  add_imm_flag,
    output logic [7:0]            add_imm_reg,
    input  logic [SIMD_WIDTH-1:0] add_out,
`ifdef SIMD_ISSUE_PERF_EN
    output logic [31:0]           perf_retired,
    output logic [31:0]           perf_illegal,
`endif
    output logic                  done,
    output logic                  err_mode
);

    logic [1:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [2:0]            mode_q, mode_d;
    logic [RF_AW-1:0]      rd_q, rd_d;
    logic [7:0]            imm_q, imm_d;
    logic [RF_AW-1:0]      raddr_a_q, raddr_a_d;
    logic [RF_AW-1:0]      raddr_b_q, raddr_b_d;
    logic [SIMD_WIDTH-1:0] add_a_q, add_a_d;
    logic [SIMD_WIDTH-1:0] add_b_q, add_b_d;
    logic [2:0]            add_mode_q, add_mode_d;
    logic                  add_sub_q, add_sub_d;
    logic                  add_immf_q, add_immf_d;
    logic [7:0]            add_imm_q, add_imm_d;
    logic                  accept;
    logic                  in_wb;
    logic                  bad_mode;

    // Gated by rst_n so ready reads 0 while reset is held.
    assign instr_ready = (state_q == ST_IDLE) && rst_n;
    assign accept      = instr_valid && instr_ready;
    assign in_wb       = (state_q == ST_WB);
    assign bad_mode    = mode_illegal(mode_q);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mode_d     = mode_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        raddr_a_d  = raddr_a_q;
        raddr_b_d  = raddr_b_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_mode_d = add_mode_q;
        add_sub_d  = add_sub_q;
        add_immf_d = add_immf_q;
        add_imm_d  = add_imm_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_READ;
                    op_d      = instr[OP_MSB:OP_LSB];
                    mode_d    = instr[MODE_MSB:MODE_LSB];
                    rd_d      = RF_AW'(instr[RD_MSB:RD_LSB]);
                    imm_d     = instr[IMM_MSB:IMM_LSB];
                    // Addresses load at accept so they sit on the port
                    // throughout READ; the RF returns data during EXEC.
                    raddr_a_d = RF_AW'(instr[RS1_MSB:RS1_LSB]);
                    raddr_b_d = RF_AW'(instr[RS2_MSB:RS2_LSB]);
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d    = ST_WB;
                add_a_d    = rf_rdata_a;
                add_b_d    = rf_rdata_b;
                add_mode_d = mode_q;
                add_sub_d  = op_q[0];
                add_immf_d = op_q[1];
                add_imm_d  = imm_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            mode_q     <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            raddr_a_q  <= '0;
            raddr_b_q  <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_mode_q <= '0;
            add_sub_q  <= 1'b0;
            add_immf_q <= 1'b0;
            add_imm_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            raddr_a_q  <= raddr_a_d;
            raddr_b_q  <= raddr_b_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_mode_q <= add_mode_d;
            add_sub_q  <= add_sub_d;
            add_immf_q <= add_immf_d;
            add_imm_q  <= add_imm_d;
        end
    end

    assign rf_raddr_a    = raddr_a_q;
    assign rf_raddr_b    = raddr_b_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign add_data_mode = add_mode_q;
    assign add_sub_flag  = add_sub_q;
    assign add_imm_flag  = add_immf_q;
    assign add_imm_reg   = add_imm_q;

    assign done     = in_wb;
    assign err_mode = in_wb && bad_mode;
    assign rf_we    = in_wb && !bad_mode;
    assign rf_waddr = in_wb ? rd_q : '0;
    assign rf_wdata = in_wb ? add_out : '0;

`ifdef SIMD_ISSUE_PERF_EN
    logic [31:0] perf_ret_q, perf_ret_d;
    logic [31:0] perf_ill_q, perf_ill_d;

    always_comb begin
        perf_ret_d = perf_ret_q + {31'd0, done};
        perf_ill_d = perf_ill_q + {31'd0, err_mode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ret_q <= '0;
            perf_ill_q <= '0;
        end else begin
            perf_ret_q <= perf_ret_d;
            perf_ill_q <= perf_ill_d;
        end
    end

    assign perf_retired = perf_ret_q;
    assign perf_illegal = perf_ill_q;
`endif

endmodule

// File: tb/tb_simd_add_issue.sv
// tb/tb_simd_add_issue.sv - scoreboard bench for simd_add_issue with adder and RF model
module tb_simd_add_issue;
    import simd_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_valid;
    logic         instr_ready;
    logic [24:0]  instr;
    logic [3:0]   raddr_a, raddr_b, waddr;
    logic [255:0] rdata_a, rdata_b, wdata;
    logic         rf_we;
    logic [255:0] add_a, add_b, add_out;
    logic [2:0]   add_mode;
    logic         add_sub, add_immf;
    logic [7:0]   add_imm;
    logic         done, err_mode;
`ifdef SIMD_ISSUE_PERF_EN
    logic [31:0]  perf_retired, perf_illegal;
`endif

    always #5 clk = ~clk;

    simd_add_issue dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_raddr_a(raddr_a), .rf_raddr_b(raddr_b),
        .rf_rdata_a(rdata_a), .rf_rdata_b(rdata_b),
        .rf_we(rf_we), .rf_waddr(waddr), .rf_wdata(wdata),
        .add_a(add_a), .add_b(add_b), .add_data_mode(add_mode),
        .add_sub_flag(add_sub), .add_imm_flag(add_immf), .add_imm_reg(add_imm),
        .add_out(add_out),
`ifdef SIMD_ISSUE_PERF_EN
        .perf_retired(perf_retired), .perf_illegal(perf_illegal),
`endif
        .done(done), .err_mode(err_mode)
    );

    simd_adder u_add (
        .a(add_a), .b(add_b), .data_mode(add_mode), .sub_flag(add_sub),
        .imm_flag(add_immf), .imm_reg(add_imm), .out(add_out)
    );

    // Register-file model: synchronous read, write port shared with bench preload.
    logic [255:0] rf [16];
    logic         tb_we = 1'b0;
    logic [3:0]   tb_addr = '0;
    logic [255:0] tb_data = '0;
    always @(posedge clk) begin
        rdata_a <= rf[raddr_a];
        rdata_b <= rf[raddr_b];
        if (rf_we) rf[waddr] <= wdata;
        else if (tb_we) rf[tb_addr] <= tb_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int           cyc;
        logic [3:0]   rd;
        logic [255:0] data;
        logic         err;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] mk(input logic [1:0] op, input logic [2:0] mode,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2, input logic [7:0] imm);
        return {op, mode, rd, rs1, rs2, imm};
    endfunction

    // Monitor: every done pops one expectation; any write without done is an error.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we && !done) chk("we_without_done", 1, 0);
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", 256'(cyc), 256'(e.cyc));
                    chk("err_mode", 256'(err_mode), 256'(e.err));
                    chk("rf_we", 256'(rf_we), 256'(!e.err));
                    if (!e.err) begin
                        chk("rf_waddr", 256'(waddr), 256'(e.rd));
                        chk("rf_wdata", wdata, e.data);
                    end
                end
            end
        end
    end

    task automatic load(input logic [3:0] a, input logic [255:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    int last_acc;

    task automatic issue(input logic [24:0] ins, input logic [255:0] exp_d,
                         input logic err, input bit hold);
        int n;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            last_acc = cyc;
            sbq.push_back('{cyc + 3, ins[19:16], exp_d, err});
        end
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    int k0, k1, k2;

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        load(4'd1, {32{8'hFF}});
        load(4'd2, {32{8'h01}});
        load(4'd5, {8{32'hDEADBEEF}});
        load(4'd7, {8{32'hFFFFFFFF}});
        load(4'd8, {8{32'h00000002}});
        load(4'd11, {8{32'hCAFEF00D}});
        #1;
        chk("rst_ctrl", 256'({instr_ready, done, err_mode, rf_we, waddr, raddr_a, raddr_b,
                              add_mode, add_sub, add_immf, add_imm}), 256'(0));
        chk("rst_add_a", add_a, '0);
        chk("rst_wdata", wdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 256'(instr_ready), 256'(1));

        // 8-bit lane wrap
        issue(mk(OP_ADD, MODE_8, 4'd3, 4'd1, 4'd2, 8'h00), '0, 1'b0, 1'b0);
        wait_idle();
        chk("r3", rf[3], '0);

        // SUBI with negative 16-bit immediate
        load(4'd1, '0);
        issue(mk(OP_SUBI, MODE_16, 4'd4, 4'd1, 4'd0, 8'h80), {16{16'h0080}}, 1'b0, 1'b0);
        wait_idle();
        chk("r4", rf[4], {16{16'h0080}});

        // 256-bit wrap with rd==rs1==rs2
        load(4'd1, {1'b1, 255'd0});
        issue(mk(OP_ADD, MODE_256, 4'd1, 4'd1, 4'd1, 8'h00), '0, 1'b0, 1'b0);
        wait_idle();
        chk("r1", rf[1], '0);

        // illegal mode: no write
        issue(mk(OP_ADD, 3'd6, 4'd5, 4'd7, 4'd8, 8'h00), '0, 1'b1, 1'b0);
        wait_idle();
        chk("r5_kept", rf[5], {8{32'hDEADBEEF}});

        // back-to-back with valid held high
        issue(mk(OP_ADD, MODE_32, 4'd6, 4'd7, 4'd8, 8'h00), {8{32'h00000001}}, 1'b0, 1'b1);
        k0 = last_acc;
        issue(mk(OP_ADDI, MODE_64, 4'd9, 4'd7, 4'd0, 8'h05), {4{64'h4}}, 1'b0, 1'b1);
        k1 = last_acc;
        issue(mk(OP_SUB, MODE_128, 4'd10, 4'd8, 4'd7, 8'h00),
              {2{128'h00000002_00000002_00000002_00000003}}, 1'b0, 1'b0);
        k2 = last_acc;
        chk("acc_gap1", 256'(k1 - k0), 256'(4));
        chk("acc_gap2", 256'(k2 - k1), 256'(4));
        wait_idle();
        chk("r6", rf[6], {8{32'h00000001}});
        chk("r9", rf[9], {4{64'h4}});
        chk("r10", rf[10], {2{128'h00000002_00000002_00000002_00000003}});
`ifdef SIMD_ISSUE_PERF_EN
        chk("perf_retired", 256'(perf_retired), 256'(7));
        chk("perf_illegal", 256'(perf_illegal), 256'(1));
`endif

        // reset while in EXEC aborts the instruction
        @(negedge clk);
        instr = mk(OP_ADD, MODE_8, 4'd11, 4'd2, 4'd2, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 256'({instr_ready, done, err_mode, rf_we, waddr, raddr_a, raddr_b,
                                add_mode, add_sub, add_immf, add_imm}), 256'(0));
        chk("abort_add_a", add_a, '0);
        chk("abort_add_b", add_b, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("r11_kept", rf[11], {8{32'hCAFEF00D}});
        issue(mk(OP_ADD, MODE_8, 4'd12, 4'd2, 4'd2, 8'h00), {32{8'h02}}, 1'b0, 1'b0);
        wait_idle();
        chk("r12", rf[12], {32{8'h02}});
`ifdef SIMD_ISSUE_PERF_EN
        chk("perf_after_rst", 256'(perf_retired), 256'(1));
`endif
        chk("sb_empty", 256'(sbq.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
